// File: rtl/mul_add_ctrl_pkg.sv
// Shared definitions for the add/multiply control unit: state codes and
// microoperation bit positions within the y vector.
package mul_add_ctrl_pkg;

    localparam int unsigned Y_W = 10;

    // Microoperation bit positions (bit 0 is reserved and always 0).
    localparam int unsigned Y_LDA = 1;  // load RA
    localparam int unsigned Y_LDB = 2;  // load RB
    localparam int unsigned Y_CLR = 3;  // clear RR
    localparam int unsigned Y_LDR = 4;  // load RR from adder
    localparam int unsigned Y_SHA = 5;  // shift RA right
    localparam int unsigned Y_SHP = 6;  // shift partial-product operand left
    localparam int unsigned Y_SUB = 7;  // adder subtract
    localparam int unsigned Y_OUT = 8;  // result output enable
    localparam int unsigned Y_KS2 = 9;  // ks2 select: 0 = sext(RB), 1 = RR feedback

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ADD    = 3'd2,
        S_MSTEP  = 3'd3,
        S_MSHIFT = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } op_e;

endpackage

// File: rtl/mul_add_ctrl_step_cnt.sv
// Multiply step counter: counts MSTEP/MSHIFT pairs and flags the last step
// (the sign-bit step whose weight is subtracted).
module step_cnt #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_last = (r_cnt == CW'(N - 1));

endmodule

// File: rtl/mul_add_ctrl.sv
// Control unit sequencing the add / shift-and-add multiply datapath: one
// microoperation vector per clock, Moore decode except the MSTEP adder controls.
module mul_add_ctrl
    import mul_add_ctrl_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           cop,
    input  logic           x_bit,
    output logic [Y_W-1:0] y,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CW = $clog2(N);

    state_e         r_state;
    state_e         w_next;
    op_e            r_cop;
    logic           w_accept;
    logic           w_cnt_clr;
    logic           w_cnt_inc;
    logic           w_last;
    logic [Y_W-1:0] w_y;
    logic           w_busy;
    logic           w_done;

    step_cnt #(
        .N  (N),
        .CW (CW)
    ) u_step_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_cnt_inc),
        .o_last (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode is captured only on accept, so later cop changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cop <= OP_ADD;
        end else if (w_accept) begin
            r_cop <= op_e'(cop);
        end
    end

    always_comb begin
        w_next    = r_state;
        w_y       = '0;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        w_accept  = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_accept  = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = S_LOAD;
                end
            end
            S_LOAD: begin
                w_y[Y_LDA] = 1'b1;
                w_y[Y_LDB] = 1'b1;
                w_y[Y_CLR] = 1'b1;
                w_next     = (r_cop == OP_MUL) ? S_MSTEP : S_ADD;
            end
            S_ADD: begin
                w_y[Y_LDR] = 1'b1;
                w_next     = S_DONE;
            end
            // Sign-bit step of a two's-complement multiplier subtracts its weight.
            S_MSTEP: begin
                w_y[Y_KS2] = 1'b1;
                w_y[Y_LDR] = x_bit;
                w_y[Y_SUB] = x_bit & w_last;
                w_next     = S_MSHIFT;
            end
            S_MSHIFT: begin
                w_y[Y_SHA] = 1'b1;
                w_y[Y_SHP] = 1'b1;
                if (w_last) begin
                    w_cnt_clr = 1'b1;
                    w_next    = S_DONE;
                end else begin
                    w_cnt_inc = 1'b1;
                    w_next    = S_MSTEP;
                end
            end
            S_DONE: begin
                w_y[Y_OUT] = 1'b1;
                w_done     = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    assign y    = w_y;
    assign busy = w_busy;
    assign done = w_done;

endmodule
